// File: rtl/operand_select_decoder_pkg.sv
// Shared opcode, second-operand select and ID/EX slot definitions for operand_select_decoder.
package operand_select_decoder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        SI_PB    = 3'b000,
        SI_IMM_I = 3'b001,
        SI_IMM_S = 3'b010,
        SI_IMM20 = 3'b011,
        SI_AUIPC = 3'b100,
        SI_PC    = 3'b101
    } si_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/operand_select_decoder_imm_field_extract.sv
// Combinational decode of the second-operand select and immediate fields from an instruction word.
module imm_field_extract
    import operand_select_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  si,
    output logic [31:0] imm12_i,
    output logic [31:0] imm12_s,
    output logic [19:0] imm20,
    output logic        known
);

    always_comb begin
        si    = SI_PB;
        known = 1'b1;
        case (instr[6:0])
            OP_R, OP_BRANCH:          si = SI_PB;
            OP_IALU, OP_LOAD, OP_JALR: si = SI_IMM_I;
            OP_STORE:                 si = SI_IMM_S;
            OP_LUI:                   si = SI_IMM20;
            OP_AUIPC:                 si = SI_AUIPC;
            OP_JAL:                   si = SI_PC;
            default:                  known = 1'b0;
        endcase
    end

    assign imm12_i = sext12(instr[31:20]);
    assign imm12_s = sext12({instr[31:25], instr[11:7]});
    assign imm20   = instr[31:12];

endmodule

// File: rtl/operand_select_decoder.sv
// ID/EX register for second-operand controls with reset > flush > stall > load priority.
// Optional macro DECODE_ILLEGAL_EN enables flagging of unrecognised opcodes.
module operand_select_decoder
    import operand_select_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [2:0]  Si,
    output logic [31:0] imm12_I,
    output logic [31:0] imm12_S,
    output logic [19:0] imm20,
    output logic [31:0] PC,
    output logic        illegal
);

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    logic [2:0]  si_d;
    logic [31:0] imm_i_d;
    logic [31:0] imm_s_d;
    logic [19:0] imm20_d;
    logic        known_d;
    logic        flag_illegal;

    slot_t       state;
    logic [2:0]  si_q;
    logic [31:0] imm_i_q;
    logic [31:0] imm_s_q;
    logic [19:0] imm20_q;
    logic [31:0] pc_q;
    logic        illegal_q;

    imm_field_extract u_extract (
        .instr   (instr),
        .si      (si_d),
        .imm12_i (imm_i_d),
        .imm12_s (imm_s_d),
        .imm20   (imm20_d),
        .known   (known_d)
    );

    // Without the feature this folds to 0, so illegal_q never leaves its reset value.
    assign flag_illegal = ILLEGAL_EN && in_valid && !known_d;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= SLOT_EMPTY;
            si_q      <= '0;
            imm_i_q   <= '0;
            imm_s_q   <= '0;
            imm20_q   <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            si_q      <= si_d;
            imm_i_q   <= imm_i_d;
            imm_s_q   <= imm_s_d;
            imm20_q   <= imm20_d;
            pc_q      <= pc_in;
            illegal_q <= flag_illegal;
            state     <= (in_valid && !flag_illegal) ? SLOT_FULL : SLOT_EMPTY;
        end
    end

    assign out_valid = (state == SLOT_FULL);
    assign Si        = si_q;
    assign imm12_I   = imm_i_q;
    assign imm12_S   = imm_s_q;
    assign imm20     = imm20_q;
    assign PC        = pc_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_select_decoder.sv
// Scoreboard bench for operand_select_decoder; honours DECODE_ILLEGAL_EN when defined.
module tb_operand_select_decoder;

    typedef struct packed {
        logic        v;
        logic [2:0]  si;
        logic [31:0] ii;
        logic [31:0] is;
        logic [19:0] u;
        logic [31:0] pc;
        logic        ill;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [2:0]  Si;
    logic [31:0] imm12_I;
    logic [31:0] imm12_S;
    logic [19:0] imm20;
    logic [31:0] PC;
    logic        illegal;

    out_t mdl = '0;
    out_t sb[$];
    out_t exp, got;
    int   passed = 0;
    int   total = 0;

    operand_select_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .instr     (instr),
        .pc_in     (pc_in),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .Si        (Si),
        .imm12_I   (imm12_I),
        .imm12_S   (imm12_S),
        .imm20     (imm20),
        .PC        (PC),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        return {out_valid, Si, imm12_I, imm12_S, imm20, PC, illegal};
    endfunction

    function automatic out_t model_load(input logic iv, input logic [31:0] ins, input logic [31:0] pcv);
        out_t n;
        bit   k;
        k = 1'b1;
        case (ins[6:0])
            7'b0110011, 7'b1100011:             n.si = 3'b000;
            7'b0010011, 7'b0000011, 7'b1100111: n.si = 3'b001;
            7'b0100011:                         n.si = 3'b010;
            7'b0110111:                         n.si = 3'b011;
            7'b0010111:                         n.si = 3'b100;
            7'b1101111:                         n.si = 3'b101;
            default: begin n.si = 3'b000; k = 1'b0; end
        endcase
        n.ii  = {{20{ins[31]}}, ins[31:20]};
        n.is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        n.u   = ins[31:12];
        n.pc  = pcv;
        n.v   = iv;
        n.ill = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        if (iv && !k) begin
            n.v   = 1'b0;
            n.ill = 1'b1;
        end
`endif
        return n;
    endfunction

    // Drives one cycle, pushes the model's prediction, then waits until after the edge.
    task automatic drive(input logic rst, input logic iv, input logic [31:0] ins,
                         input logic [31:0] pcv, input logic st, input logic fl);
        reset = rst; in_valid = iv; instr = ins; pc_in = pcv; stall = st; flush = fl;
        if (rst || fl) mdl = '0;
        else if (!st)  mdl = model_load(iv, ins, pcv);
        sb.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'h00500093, 32'h10, 1'b0, 1'b0);
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL reset_sb got=%h exp=%h", got, exp); else passed++;
            total++;
            if (got !== '0) $display("FAIL reset_zero got=%h exp=0", got); else passed++;
        end
    endtask

    task automatic test_addi();
        drive(1'b0, 1'b1, 32'h00500093, 32'h00000010, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL addi_sb got=%h exp=%h", got, exp); else passed++;
        total++;
        if ({out_valid, Si, imm12_I, PC} !== {1'b1, 3'b001, 32'h5, 32'h10})
            $display("FAIL addi_fields got=%b/%b/%h/%h exp=1/001/00000005/00000010", out_valid, Si, imm12_I, PC);
        else passed++;
    endtask

    task automatic test_store();
        drive(1'b0, 1'b1, 32'hFE20AE23, 32'h00000014, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL store_sb got=%h exp=%h", got, exp); else passed++;
        total++;
        if ({Si, imm12_S, imm12_I} !== {3'b010, 32'hFFFFFFFC, 32'hFFFFFFE2})
            $display("FAIL store_fields got=%b/%h/%h exp=010/fffffffc/ffffffe2", Si, imm12_S, imm12_I);
        else passed++;
    endtask

    task automatic test_lui_jal();
        drive(1'b0, 1'b1, 32'hABCDE2B7, 32'h00000018, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL lui_sb got=%h exp=%h", got, exp); else passed++;
        total++;
        if ({Si, imm20} !== {3'b011, 20'hABCDE})
            $display("FAIL lui_fields got=%b/%h exp=011/abcde", Si, imm20);
        else passed++;
        drive(1'b0, 1'b1, 32'h0080006F, 32'h0000001C, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL jal_sb got=%h exp=%h", got, exp); else passed++;
        total++;
        if ({out_valid, Si} !== {1'b1, 3'b101})
            $display("FAIL jal_fields got=%b/%b exp=1/101", out_valid, Si);
        else passed++;
    endtask

    task automatic test_stall_flush();
        out_t held;
        drive(1'b0, 1'b1, 32'h00500093, 32'h00000020, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL stall_load got=%h exp=%h", got, exp); else passed++;
        held = got;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i != 1), 32'hABCDE2B7 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp || got !== held)
                $display("FAIL stall_hold got=%h exp=%h", got, exp);
            else passed++;
        end
        // reset while stalled still clears
        drive(1'b1, 1'b1, 32'h0080006F, 32'h40, 1'b1, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL stall_reset got=%h exp=%h", got, exp); else passed++;
        drive(1'b0, 1'b1, 32'h0080006F, 32'h44, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL resume got=%h exp=%h", got, exp); else passed++;
        drive(1'b0, 1'b1, 32'h00500093, 32'h48, 1'b1, 1'b1);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp || {out_valid, Si} !== 4'b0000)
            $display("FAIL stall_flush got=%h exp=%h", got, exp);
        else passed++;
    endtask

    task automatic test_in_valid_low();
        drive(1'b0, 1'b1, 32'h0080006F, 32'h50, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL ivl_setup got=%h exp=%h", got, exp); else passed++;
        drive(1'b0, 1'b0, 32'hFE20AE23, 32'h54, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp || {out_valid, Si, PC} !== {1'b0, 3'b010, 32'h54})
            $display("FAIL in_valid_low got=%h exp=%h", got, exp);
        else passed++;
    endtask

    task automatic test_illegal();
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h60, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL illegal_sb got=%h exp=%h", got, exp); else passed++;
        total++;
`ifdef DECODE_ILLEGAL_EN
        if ({illegal, out_valid, Si} !== {1'b1, 1'b0, 3'b000})
            $display("FAIL illegal_flag got=%b/%b/%b exp=1/0/000", illegal, out_valid, Si);
        else passed++;
`else
        if ({illegal, out_valid, Si} !== {1'b0, 1'b1, 3'b000})
            $display("FAIL illegal_flag got=%b/%b/%b exp=0/1/000", illegal, out_valid, Si);
        else passed++;
`endif
        drive(1'b0, 1'b1, 32'h00500093, 32'h64, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp || illegal !== 1'b0) $display("FAIL illegal_clear got=%h exp=%h", got, exp); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [10];
        logic [31:0] ins;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
        for (int i = 0; i < 80; i++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 9)];
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ins, $urandom(),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_lui_jal();
        test_stall_flush();
        test_in_valid_low();
        test_illegal();
        test_back_to_back();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
